// File: rtl/sort_engine.sv
// In-place exchange sorter: host loads a word RAM, pulses start, and the FSM
// compares every pair (i < j), swapping out-of-order words and counting swaps.
module sort_engine #(
    parameter int N = 8,
    parameter int L = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           mode_desc,
    input  logic [L:0]     len,
    input  logic           wr_init,
    input  logic           rd,
    input  logic [L-1:0]   addr,
    input  logic [N-1:0]   data_in,
    output logic [N-1:0]   data_out,
    output logic           rd_valid,
    output logic           busy,
    output logic           done,
    output logic [2*L-1:0] swap_cnt
);

    localparam int DEPTH = 2 ** L;
    localparam logic [L:0]     DEPTH_W  = (L+1)'(DEPTH);
    localparam logic [L:0]     ONE_N    = (L+1)'(1);
    localparam logic [L:0]     TWO_N    = (L+1)'(2);
    localparam logic [L-1:0]   ONE_A    = L'(1);
    localparam logic [2*L-1:0] ONE_C    = (2*L)'(1);

    typedef enum logic [3:0] {
        IDLE, LDA, LDB, CMP, WRI, WRJ, NXJ, NXI, DONE
    } state_t;

    logic [N-1:0] mem_q [DEPTH];

    state_t         state_q, state_d;
    logic [L-1:0]   i_q, i_d;
    logic [L-1:0]   j_q, j_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [L:0]     n_q, n_d;
    logic           mode_q, mode_d;
    logic [2*L-1:0] swap_cnt_q, swap_cnt_d;
    logic [N-1:0]   data_out_q, data_out_d;
    logic           rd_valid_q, rd_valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           mem_we;
    logic [L-1:0]   mem_waddr;
    logic [N-1:0]   mem_wdata;
    logic [L:0]     len_clip;
    logic           swap;

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        a_d        = a_q;
        b_d        = b_q;
        n_d        = n_q;
        mode_d     = mode_q;
        swap_cnt_d = swap_cnt_q;
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = addr;
        mem_wdata  = data_in;
        len_clip   = (len > DEPTH_W) ? DEPTH_W : len;
        swap       = mode_q ? (a_q < b_q) : (a_q > b_q);

        // Host port is only live while idle; async RAM read gives the pre-write value.
        if (!busy_q) begin
            if (rd) begin
                rd_valid_d = 1'b1;
                data_out_d = mem_q[addr];
            end
            if (wr_init) begin
                mem_we = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d     = mode_desc;
                    n_d        = len_clip;
                    i_d        = '0;
                    j_d        = '0;
                    swap_cnt_d = '0;
                    busy_d     = 1'b1;
                    state_d    = (len_clip < TWO_N) ? DONE : LDA;
                end
            end
            LDA: begin
                a_d     = mem_q[i_q];
                j_d     = i_q + ONE_A;
                state_d = LDB;
            end
            LDB: begin
                b_d     = mem_q[j_q];
                state_d = CMP;
            end
            CMP: begin
                state_d = swap ? WRI : NXJ;
            end
            WRI: begin
                mem_we    = 1'b1;
                mem_waddr = i_q;
                mem_wdata = b_q;
                state_d   = WRJ;
            end
            // A keeps tracking the word now held at M[i].
            WRJ: begin
                mem_we     = 1'b1;
                mem_waddr  = j_q;
                mem_wdata  = a_q;
                a_d        = b_q;
                swap_cnt_d = swap_cnt_q + ONE_C;
                state_d    = NXJ;
            end
            NXJ: begin
                if ({1'b0, j_q} == n_q - ONE_N) begin
                    state_d = NXI;
                end else begin
                    j_d     = j_q + ONE_A;
                    state_d = LDB;
                end
            end
            NXI: begin
                if ({1'b0, i_q} == n_q - TWO_N) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q + ONE_A;
                    state_d = LDA;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            i_q        <= '0;
            j_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            n_q        <= '0;
            mode_q     <= 1'b0;
            swap_cnt_q <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            a_q        <= a_d;
            b_q        <= b_d;
            n_q        <= n_d;
            mode_q     <= mode_d;
            swap_cnt_q <= swap_cnt_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Word RAM keeps its contents through reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign swap_cnt = swap_cnt_q;

endmodule

// File: tb/tb_sort_engine.sv
// Directed bench for sort_engine: loads, sorts and reads back with hand-computed
// latencies, swap counts and contents, plus busy lockout and mid-sort reset.
module tb_sort_engine;

    logic       clk;
    logic       rst;
    logic       start;
    logic       mode_desc;
    logic [4:0] len;
    logic       wr_init;
    logic       rd;
    logic [3:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       rd_valid;
    logic       busy;
    logic       done;
    logic [7:0] swap_cnt;

    int compared;
    int mismatched;
    int img [16];
    int expv [16];

    sort_engine #(.N(8), .L(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode_desc (mode_desc),
        .len       (len),
        .wr_init   (wr_init),
        .rd        (rd),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .rd_valid  (rd_valid),
        .busy      (busy),
        .done      (done),
        .swap_cnt  (swap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic writeWord(input int a, input int d);
        @(negedge clk);
        wr_init = 1'b1;
        addr    = a[3:0];
        data_in = d[7:0];
        @(negedge clk);
        wr_init = 1'b0;
    endtask

    task automatic readWord(input int a, output int d, output int v);
        @(negedge clk);
        rd   = 1'b1;
        addr = a[3:0];
        @(posedge clk);
        #1;
        d = int'(data_out);
        v = int'(rd_valid);
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic applyStimulus(input int cnt);
        for (int k = 0; k < cnt; k++) writeWord(k, img[k]);
    endtask

    task automatic checkImage(input string tag, input int cnt);
        int d;
        int v;
        for (int k = 0; k < cnt; k++) begin
            readWord(k, d, v);
            checkOutput($sformatf("%s rd_valid[%0d]", tag, k), v, 1);
            checkOutput($sformatf("%s mem[%0d]", tag, k), d, expv[k]);
        end
    endtask

    task automatic runSort(input string tag, input int ln, input bit desc,
                           input int expLat, input int expSwaps);
        int lat;
        lat = -1;
        @(negedge clk);
        len       = ln[4:0];
        mode_desc = desc;
        start     = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({tag, " busy after start"}, busy, 1);
        @(negedge clk);
        start     = 1'b0;
        mode_desc = 1'b0;
        for (int k = 1; k <= 2000; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        checkOutput({tag, " latency"}, lat, expLat);
        checkOutput({tag, " busy at done"}, busy, 0);
        checkOutput({tag, " swap_cnt"}, swap_cnt, expSwaps);
        @(posedge clk);
        #1;
        checkOutput({tag, " done one cycle"}, done, 0);
    endtask

    task automatic setFour(input int a, input int b, input int c, input int d);
        img[0] = a; img[1] = b; img[2] = c; img[3] = d;
    endtask

    task automatic setReverse16();
        for (int k = 0; k < 16; k++) begin
            img[k]  = 15 - k;
            expv[k] = k;
        end
    endtask

    initial begin
        int lat;
        int d;
        int v;
        compared   = 0;
        mismatched = 0;
        rst = 1'b1; start = 1'b0; mode_desc = 1'b0; len = '0;
        wr_init = 1'b0; rd = 1'b0; addr = '0; data_in = '0;

        #2;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset rd_valid", rd_valid, 0);
        checkOutput("reset data_out", data_out, 0);
        checkOutput("reset swap_cnt", swap_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        // Case 1: ascending four-word sort
        setFour(5, 3, 7, 1);
        applyStimulus(4);
        runSort("c1", 4, 1'b0, 33, 4);
        expv[0] = 1; expv[1] = 3; expv[2] = 5; expv[3] = 7;
        checkImage("c1", 4);

        // Case 2: same data, descending
        applyStimulus(4);
        runSort("c2", 4, 1'b1, 29, 2);
        expv[0] = 7; expv[1] = 5; expv[2] = 3; expv[3] = 1;
        checkImage("c2", 4);

        // Case 3: full-depth reversed data
        setReverse16();
        applyStimulus(16);
        runSort("c3", 16, 1'b0, 631, 120);
        checkImage("c3", 16);

        // Case 4: equal keys, then trivially short lengths
        setFour(4, 4, 4, 4);
        applyStimulus(4);
        runSort("c4", 4, 1'b0, 25, 0);
        expv[0] = 4; expv[1] = 4; expv[2] = 4; expv[3] = 4;
        checkImage("c4", 4);
        runSort("c4 len1", 1, 1'b0, 1, 0);
        runSort("c4 len0", 0, 1'b0, 1, 0);

        // Case 5a: host traffic and start while busy are ignored
        setFour(5, 3, 7, 1);
        applyStimulus(4);
        @(negedge clk);
        len = 5'd4; mode_desc = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        wr_init = 1'b1; addr = 4'd0; data_in = 8'hFF; rd = 1'b1;
        start = 1'b1; mode_desc = 1'b1; len = 5'd2;
        @(posedge clk);
        #1;
        checkOutput("c5 rd_valid while busy", rd_valid, 0);
        @(negedge clk);
        wr_init = 1'b0; rd = 1'b0; start = 1'b0; mode_desc = 1'b0;
        lat = -1;
        for (int k = 5; k <= 2000; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        checkOutput("c5 latency", lat, 33);
        checkOutput("c5 swap_cnt", swap_cnt, 4);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("c5 no second run", busy, 0);
        expv[0] = 1; expv[1] = 3; expv[2] = 5; expv[3] = 7;
        checkImage("c5", 4);
        readWord(4, d, v);
        checkOutput("c5 mem[4] untouched", d, 4);

        // Case 5b: oversize len clamps to full depth
        setReverse16();
        applyStimulus(16);
        runSort("c5 len20", 20, 1'b0, 631, 120);
        checkImage("c5 len20", 16);

        // Case 6: asynchronous reset in the middle of a long sort
        applyStimulus(16);
        @(negedge clk);
        len = 5'd16; mode_desc = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        checkOutput("c6 swaps before reset", swap_cnt != 8'd0, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("c6 busy", busy, 0);
        checkOutput("c6 done", done, 0);
        checkOutput("c6 rd_valid", rd_valid, 0);
        checkOutput("c6 swap_cnt", swap_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        setFour(5, 3, 7, 1);
        applyStimulus(4);
        runSort("c6 rerun", 4, 1'b0, 33, 4);
        expv[0] = 1; expv[1] = 3; expv[2] = 5; expv[3] = 7;
        checkImage("c6 rerun", 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
